q_sys_log_ring_ram: RTL and testbench
=====================================

// Module: q_sys_log_ring_ram
// PURPOSE
//  Parametrised dual-port logging RAM, successor to the fixed 16x16K on-chip log RAM.
//  A streaming logger port writes samples into a circular buffer.
//  An Avalon-MM memory slave (avs) gives the Nios random read/write access to that buffer.
//  An Avalon-MM CSR slave holds control, write pointer, fill count and status, and drives an IRQ.
// PARAMETERS
//  DATA_WIDTH  16  word width in bits; must be a multiple of 8
//  ADDR_WIDTH  14  word address width; DEPTH = 2**ADDR_WIDTH
//  BE_WIDTH    DATA_WIDTH/8  byteenable width (derived, do not override)
// PORTS
//  clk               in   1           system clock; all logic in this domain
//  reset_n           in   1           asynchronous active-low reset
//  avs_address       in   ADDR_WIDTH  word address
//  avs_chipselect    in   1           slave select
//  avs_read          in   1           read strobe
//  avs_write         in   1           write strobe
//  avs_byteenable    in   BE_WIDTH    byte lane enables for writes
//  avs_writedata     in   DATA_WIDTH  write data
//  avs_readdata      out  DATA_WIDTH  read data, registered
//  avs_readdatavalid out  1           high one cycle per accepted read
//  csr_address       in   2           CSR word select
//  csr_read          in   1           CSR read strobe
//  csr_write         in   1           CSR write strobe
//  csr_writedata     in   32          CSR write data
//  csr_readdata      out  32          CSR read data; fixed latency 1, no valid signal
//  log_valid         in   1           sample offered
//  log_data          in   DATA_WIDTH  sample value
//  log_ready         out  1           sample is accepted when log_valid & log_ready
//  freeze            in   1           blocks logging while high
//  irq               out  1           interrupt, level
// BEHAVIOUR
//  Reset: all outputs 0; CTRL=0, WR_PTR=0, COUNT=0, all STATUS bits 0.
//   RAM contents are not initialised.
//  CSR map:
//   0 CTRL: b0 enable, b1 mode (0 circular, 1 stop-when-full), b2 clear (write-1, self-clearing, reads 0), b3 irq_en
//   1 WR_PTR: next logger write address, read-only
//   2 COUNT: valid entries, 0..DEPTH, ADDR_WIDTH+1 bits, read-only
//   3 STATUS: b0 wrapped (sticky, W1C), b1 full (read-only, COUNT==DEPTH), b2 overflow (sticky, W1C)
//   Unused bits read 0.
//  log_ready = enable & ~freeze & ~(mode & full) & ~clear_pulse; combinational.
//  Accepted sample:
//   - writes RAM[WR_PTR] = log_data (all byte lanes).
//   - WR_PTR increments mod DEPTH.
//   - COUNT increments and saturates at DEPTH.
//   - wrap DEPTH-1 -> 0 sets wrapped.
//  overflow sets on any cycle with enable & log_valid & ~log_ready. Sample is dropped.
//  clear:
//   - next cycle WR_PTR=0, COUNT=0, wrapped=0, overflow=0.
//   - a sample offered in the clear cycle is dropped and does not set overflow.
//   - clear wins over W1C and over logging in the same cycle.
//  Avalon memory reads:
//   - avs_chipselect & avs_read captures RAM[avs_address].
//   - avs_readdata and avs_readdatavalid are driven on the next edge; 1 read per cycle, no waitrequest.
//  Avalon memory writes (avs_chipselect & avs_write):
//   - update only the lanes set in avs_byteenable.
//   - read-during-write at the same address returns the old data.
//  Collision: logger and avs write the same address in the same cycle.
//   - the logger data is stored and the avs write is discarded entirely.
//   - different addresses both complete.
//  avs read and write strobes together: the write is performed and the read returns the old data.
//  irq = irq_en & (full | overflow); registered, one-cycle lag.
//  freeze does not affect avs or CSR access.
//  Async reset mid-operation clears all state immediately; any read in flight produces no readdatavalid.
// TESTING
//  1 Circular, 5 samples: CTRL=1, push 0xA000..0xA004.
//    -> WR_PTR=5, COUNT=5. avs read addr 2 -> 0xA002 with readdatavalid exactly 1 cycle later.
//  2 Wrap, ADDR_WIDTH=4, circular: push 20 samples s0..s19.
//    -> WR_PTR=4, COUNT=16, wrapped=1, full=1, RAM[0]=s16, RAM[15]=s15.
//  3 Stop mode, ADDR_WIDTH=4, CTRL=3, 17 samples offered.
//    -> log_ready low after the 16th, full=1, overflow=1.
//    -> irq stays 0 until irq_en is written, then irq=1 next cycle. W1C overflow with full still set keeps irq=1.
//  4 Byte lanes: write 0x1234 to addr 7 (be=11), then 0xABCD with be=10.
//    -> read addr 7 = 0xAB34.
//  5 Collision at addr 3: logger writes 0x5555 while avs writes 0xAAAA in the same cycle.
//    -> RAM[3]=0x5555, WR_PTR advances by 1.
//  6 Clear plus async reset: clear during an active stream.
//    -> the sample in that cycle is dropped, WR_PTR=0, COUNT=0, overflow stays 0.
//    -> reset_n low mid-read: readdatavalid=0 immediately, all CSRs read 0 after release.

Source files
------------

// File: rtl/q_sys_log_ring_ram.sv
// Dual-port circular logging RAM: streaming logger port, Avalon-MM memory
// slave for random access, and an Avalon-MM CSR slave with a level IRQ.
module q_sys_log_ring_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 14,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] avs_address,
  input  logic                  avs_chipselect,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [BE_WIDTH-1:0]   avs_byteenable,
  input  logic [DATA_WIDTH-1:0] avs_writedata,
  output logic [DATA_WIDTH-1:0] avs_readdata,
  output logic                  avs_readdatavalid,
  input  logic [1:0]            csr_address,
  input  logic                  csr_read,
  input  logic                  csr_write,
  input  logic [31:0]           csr_writedata,
  output logic [31:0]           csr_readdata,
  input  logic                  log_valid,
  input  logic [DATA_WIDTH-1:0] log_data,
  output logic                  log_ready,
  input  logic                  freeze,
  output logic                  irq
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LP_FULL =
    {1'b1, {ADDR_WIDTH{1'b0}}};

  logic                  r_en;
  logic                  r_mode;
  logic                  r_irq_en;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_wrapped;
  logic                  r_ovf;
  logic                  r_irq;
  logic                  r_rvalid;
  logic [31:0]           r_csr_rd;

  logic                  w_ctrl_wr;
  logic                  w_sts_wr;
  logic                  w_clr;
  logic                  w_full;
  logic                  w_ready;
  logic                  w_log_acc;
  logic                  w_wrap;
  logic                  w_ovf_set;
  logic                  w_avs_rd;
  logic                  w_avs_we;
  logic [31:0]           w_csr_rd;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused;

  assign w_ctrl_wr = csr_write & (csr_address == 2'd0);
  assign w_sts_wr  = csr_write & (csr_address == 2'd3);
  assign w_clr     = w_ctrl_wr & csr_writedata[2];
  assign w_full    = (r_count == LP_FULL);
  assign w_ready   = r_en & ~freeze & ~(r_mode & w_full) & ~w_clr;
  assign w_log_acc = log_valid & w_ready;
  assign w_wrap    = w_log_acc & (r_wr_ptr == {ADDR_WIDTH{1'b1}});
  assign w_ovf_set = r_en & log_valid & ~w_ready & ~w_clr;
  assign w_avs_rd  = avs_chipselect & avs_read;
  // Logger owns a same-address collision; the avs write is dropped whole.
  assign w_avs_we  = avs_chipselect & avs_write &
                     ~(w_log_acc & (avs_address == r_wr_ptr));
  assign w_unused  = ^csr_writedata[31:4];

  // Per-lane storage so byte-enabled writes map onto simple RAM blocks.
  for (genvar g = 0; g < BE_WIDTH; g++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_q;

    // Logger and avs write ports; both land when addresses differ.
    always_ff @(posedge clk) begin
      if (w_log_acc)
        r_mem[r_wr_ptr] <= log_data[8*g +: 8];
      if (w_avs_we && avs_byteenable[g])
        r_mem[avs_address] <= avs_writedata[8*g +: 8];
    end

    // Registered read port; sees pre-write contents.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        r_q <= '0;
      else if (w_avs_rd)
        r_q <= r_mem[avs_address];
    end

    assign w_rdata[8*g +: 8] = r_q;
  end

  // Read-valid strobe follows the accepted read by one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_rvalid <= 1'b0;
    else
      r_rvalid <= w_avs_rd;
  end

  // Control register fields.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en     <= 1'b0;
      r_mode   <= 1'b0;
      r_irq_en <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_en     <= csr_writedata[0];
      r_mode   <= csr_writedata[1];
      r_irq_en <= csr_writedata[3];
    end
  end

  // Write pointer and saturating fill count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_clr) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_log_acc) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
      if (!w_full)
        r_count <= r_count + 1'b1;
    end
  end

  // Sticky status bits; a new event beats a W1C in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrapped <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_clr) begin
      r_wrapped <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_sts_wr && csr_writedata[0])
        r_wrapped <= 1'b0;
      if (w_wrap)
        r_wrapped <= 1'b1;
      if (w_sts_wr && csr_writedata[2])
        r_ovf <= 1'b0;
      if (w_ovf_set)
        r_ovf <= 1'b1;
    end
  end

  // Interrupt level, registered from current state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_irq <= 1'b0;
    else
      r_irq <= r_irq_en & (w_full | r_ovf);
  end

  // CSR read mux.
  always_comb begin
    w_csr_rd = '0;
    unique case (csr_address)
      2'd0: w_csr_rd[3:0] = {r_irq_en, 1'b0, r_mode, r_en};
      2'd1: w_csr_rd[ADDR_WIDTH-1:0] = r_wr_ptr;
      2'd2: w_csr_rd[ADDR_WIDTH:0] = r_count;
      2'd3: w_csr_rd[2:0] = {r_ovf, w_full, r_wrapped};
    endcase
  end

  // CSR read data, fixed one-cycle latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_csr_rd <= '0;
    else if (csr_read)
      r_csr_rd <= w_csr_rd;
  end

  assign avs_readdata      = w_rdata;
  assign avs_readdatavalid = r_rvalid;
  assign csr_readdata      = r_csr_rd;
  assign log_ready         = w_ready;
  assign irq               = r_irq;

endmodule

// File: tb/tb_q_sys_log_ring_ram.sv
// Directed testbench for q_sys_log_ring_ram with a 16-deep ring.
// Each scenario task drives stimulus and checks results inline.
module tb_q_sys_log_ring_ram;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] avs_address = '0;
  logic          avs_chipselect = 1'b0;
  logic          avs_read = 1'b0;
  logic          avs_write = 1'b0;
  logic [BW-1:0] avs_byteenable = '0;
  logic [DW-1:0] avs_writedata = '0;
  logic [DW-1:0] avs_readdata;
  logic          avs_readdatavalid;
  logic [1:0]    csr_address = '0;
  logic          csr_read = 1'b0;
  logic          csr_write = 1'b0;
  logic [31:0]   csr_writedata = '0;
  logic [31:0]   csr_readdata;
  logic          log_valid = 1'b0;
  logic [DW-1:0] log_data = '0;
  logic          log_ready;
  logic          freeze = 1'b0;
  logic          irq;

  int n_tests = 0;
  int n_fail  = 0;

  q_sys_log_ring_ram #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .avs_address      (avs_address),
    .avs_chipselect   (avs_chipselect),
    .avs_read         (avs_read),
    .avs_write        (avs_write),
    .avs_byteenable   (avs_byteenable),
    .avs_writedata    (avs_writedata),
    .avs_readdata     (avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .csr_address      (csr_address),
    .csr_read         (csr_read),
    .csr_write        (csr_write),
    .csr_writedata    (csr_writedata),
    .csr_readdata     (csr_readdata),
    .log_valid        (log_valid),
    .log_data         (log_data),
    .log_ready        (log_ready),
    .freeze           (freeze),
    .irq              (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    csr_address   = a;
    csr_writedata = d;
    csr_write     = 1'b1;
    tick();
    csr_write     = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    csr_address = a;
    csr_read    = 1'b1;
    tick();
    csr_read    = 1'b0;
    d = csr_readdata;
  endtask

  task automatic push(input logic [DW-1:0] d);
    log_data  = d;
    log_valid = 1'b1;
    tick();
    log_valid = 1'b0;
  endtask

  task automatic avs_rd(input logic [AW-1:0] a,
                        output logic [DW-1:0] d, output logic v);
    avs_address    = a;
    avs_chipselect = 1'b1;
    avs_read       = 1'b1;
    tick();
    avs_chipselect = 1'b0;
    avs_read       = 1'b0;
    d = avs_readdata;
    v = avs_readdatavalid;
  endtask

  task automatic avs_wr(input logic [AW-1:0] a, input logic [BW-1:0] be,
                        input logic [DW-1:0] d);
    avs_address    = a;
    avs_byteenable = be;
    avs_writedata  = d;
    avs_chipselect = 1'b1;
    avs_write      = 1'b1;
    tick();
    avs_chipselect = 1'b0;
    avs_write      = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    n_tests++;
    if ({log_ready, irq, avs_readdatavalid} !== 3'b000) begin
      $display("FAIL reset_outputs got %b want 000",
               {log_ready, irq, avs_readdatavalid});
      n_fail++;
    end
    for (int i = 0; i < 4; i++) begin
      csr_rd(2'(i), d);
      n_tests++;
      if (d !== 32'h0) begin
        $display("FAIL reset_csr%0d got %h want 0", i, d);
        n_fail++;
      end
    end
  endtask

  task automatic test_circular();
    logic [31:0] d;
    logic [DW-1:0] r;
    logic v;
    csr_wr(2'd0, 32'h1);
    for (int i = 0; i < 5; i++) push(16'hA000 + 16'(i));
    csr_rd(2'd1, d);
    n_tests++;
    if (d !== 32'd5) begin
      $display("FAIL circ_wrptr got %0d want 5", d);
      n_fail++;
    end
    csr_rd(2'd2, d);
    n_tests++;
    if (d !== 32'd5) begin
      $display("FAIL circ_count got %0d want 5", d);
      n_fail++;
    end
    n_tests++;
    if (avs_readdatavalid !== 1'b0) begin
      $display("FAIL circ_rv_idle got %b want 0", avs_readdatavalid);
      n_fail++;
    end
    avs_rd(4'd2, r, v);
    n_tests++;
    if (v !== 1'b1 || r !== 16'hA002) begin
      $display("FAIL circ_read got v=%b d=%h want v=1 d=a002", v, r);
      n_fail++;
    end
    tick();
    n_tests++;
    if (avs_readdatavalid !== 1'b0) begin
      $display("FAIL circ_rv_pulse got %b want 0", avs_readdatavalid);
      n_fail++;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    logic [DW-1:0] r;
    logic v;
    csr_wr(2'd0, 32'h5);
    for (int i = 0; i < 20; i++) push(16'hB000 + 16'(i));
    csr_rd(2'd1, d);
    n_tests++;
    if (d !== 32'd4) begin
      $display("FAIL wrap_wrptr got %0d want 4", d);
      n_fail++;
    end
    csr_rd(2'd2, d);
    n_tests++;
    if (d !== 32'd16) begin
      $display("FAIL wrap_count got %0d want 16", d);
      n_fail++;
    end
    csr_rd(2'd3, d);
    n_tests++;
    if (d !== 32'h3) begin
      $display("FAIL wrap_status got %h want 3", d);
      n_fail++;
    end
    avs_rd(4'd0, r, v);
    n_tests++;
    if (r !== 16'hB010) begin
      $display("FAIL wrap_ram0 got %h want b010", r);
      n_fail++;
    end
    avs_rd(4'd15, r, v);
    n_tests++;
    if (r !== 16'hB00F) begin
      $display("FAIL wrap_ram15 got %h want b00f", r);
      n_fail++;
    end
  endtask

  task automatic test_stop();
    logic [31:0] d;
    csr_wr(2'd0, 32'h7);
    for (int i = 0; i < 16; i++) push(16'hC100 + 16'(i));
    n_tests++;
    if (log_ready !== 1'b0) begin
      $display("FAIL stop_ready got %b want 0", log_ready);
      n_fail++;
    end
    push(16'hC1FF);
    csr_rd(2'd1, d);
    n_tests++;
    if (d !== 32'd0) begin
      $display("FAIL stop_wrptr got %0d want 0", d);
      n_fail++;
    end
    csr_rd(2'd3, d);
    n_tests++;
    if (d !== 32'h7) begin
      $display("FAIL stop_status got %h want 7", d);
      n_fail++;
    end
    n_tests++;
    if (irq !== 1'b0) begin
      $display("FAIL stop_irq_off got %b want 0", irq);
      n_fail++;
    end
    csr_wr(2'd0, 32'hB);
    n_tests++;
    if (irq !== 1'b0) begin
      $display("FAIL stop_irq_lag got %b want 0", irq);
      n_fail++;
    end
    tick();
    n_tests++;
    if (irq !== 1'b1) begin
      $display("FAIL stop_irq_on got %b want 1", irq);
      n_fail++;
    end
    csr_wr(2'd3, 32'h4);
    tick();
    n_tests++;
    if (irq !== 1'b1) begin
      $display("FAIL stop_irq_full got %b want 1", irq);
      n_fail++;
    end
    csr_rd(2'd3, d);
    n_tests++;
    if (d !== 32'h3) begin
      $display("FAIL stop_w1c got %h want 3", d);
      n_fail++;
    end
    csr_wr(2'd0, 32'h4);
    tick();
    n_tests++;
    if (irq !== 1'b0) begin
      $display("FAIL stop_irq_clr got %b want 0", irq);
      n_fail++;
    end
  endtask

  task automatic test_byte_lanes();
    logic [DW-1:0] r;
    logic v;
    avs_wr(4'd7, 2'b11, 16'h1234);
    avs_wr(4'd7, 2'b10, 16'hABCD);
    avs_rd(4'd7, r, v);
    n_tests++;
    if (r !== 16'hAB34) begin
      $display("FAIL lanes got %h want ab34", r);
      n_fail++;
    end
    avs_address    = 4'd7;
    avs_byteenable = 2'b11;
    avs_writedata  = 16'h1111;
    avs_chipselect = 1'b1;
    avs_read       = 1'b1;
    avs_write      = 1'b1;
    tick();
    avs_chipselect = 1'b0;
    avs_read       = 1'b0;
    avs_write      = 1'b0;
    n_tests++;
    if (avs_readdata !== 16'hAB34 || avs_readdatavalid !== 1'b1) begin
      $display("FAIL rdw_old got %h v=%b want ab34 v=1",
               avs_readdata, avs_readdatavalid);
      n_fail++;
    end
    avs_rd(4'd7, r, v);
    n_tests++;
    if (r !== 16'h1111) begin
      $display("FAIL rdw_new got %h want 1111", r);
      n_fail++;
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    logic [DW-1:0] r;
    logic v;
    csr_wr(2'd0, 32'h5);
    for (int i = 0; i < 3; i++) push(16'hD000 + 16'(i));
    log_data       = 16'h5555;
    log_valid      = 1'b1;
    avs_address    = 4'd3;
    avs_byteenable = 2'b11;
    avs_writedata  = 16'hAAAA;
    avs_chipselect = 1'b1;
    avs_write      = 1'b1;
    tick();
    log_valid      = 1'b0;
    avs_chipselect = 1'b0;
    avs_write      = 1'b0;
    csr_rd(2'd1, d);
    n_tests++;
    if (d !== 32'd4) begin
      $display("FAIL coll_wrptr got %0d want 4", d);
      n_fail++;
    end
    log_data       = 16'h6666;
    log_valid      = 1'b1;
    avs_address    = 4'd9;
    avs_writedata  = 16'h9999;
    avs_chipselect = 1'b1;
    avs_write      = 1'b1;
    tick();
    log_valid      = 1'b0;
    avs_chipselect = 1'b0;
    avs_write      = 1'b0;
    avs_rd(4'd3, r, v);
    n_tests++;
    if (r !== 16'h5555) begin
      $display("FAIL coll_ram3 got %h want 5555", r);
      n_fail++;
    end
    avs_rd(4'd4, r, v);
    n_tests++;
    if (r !== 16'h6666) begin
      $display("FAIL diff_log got %h want 6666", r);
      n_fail++;
    end
    avs_rd(4'd9, r, v);
    n_tests++;
    if (r !== 16'h9999) begin
      $display("FAIL diff_avs got %h want 9999", r);
      n_fail++;
    end
  endtask

  task automatic test_clear_reset();
    logic [31:0] d;
    logic [DW-1:0] r;
    logic v;
    csr_wr(2'd0, 32'h5);
    for (int i = 0; i < 3; i++) push(16'hC000 + 16'(i));
    log_data      = 16'hC0FF;
    log_valid     = 1'b1;
    csr_address   = 2'd0;
    csr_writedata = 32'h5;
    csr_write     = 1'b1;
    #1;
    n_tests++;
    if (log_ready !== 1'b0) begin
      $display("FAIL clr_ready got %b want 0", log_ready);
      n_fail++;
    end
    tick();
    log_valid = 1'b0;
    csr_write = 1'b0;
    csr_rd(2'd1, d);
    n_tests++;
    if (d !== 32'd0) begin
      $display("FAIL clr_wrptr got %0d want 0", d);
      n_fail++;
    end
    csr_rd(2'd2, d);
    n_tests++;
    if (d !== 32'd0) begin
      $display("FAIL clr_count got %0d want 0", d);
      n_fail++;
    end
    csr_rd(2'd3, d);
    n_tests++;
    if (d !== 32'h0) begin
      $display("FAIL clr_status got %h want 0", d);
      n_fail++;
    end
    avs_rd(4'd3, r, v);
    n_tests++;
    if (r !== 16'h5555) begin
      $display("FAIL clr_dropped got %h want 5555", r);
      n_fail++;
    end
    csr_wr(2'd0, 32'h9);
    push(16'hE000);
    avs_address    = 4'd0;
    avs_chipselect = 1'b1;
    avs_read       = 1'b1;
    tick();
    n_tests++;
    if (avs_readdatavalid !== 1'b1) begin
      $display("FAIL rst_pre_rv got %b want 1", avs_readdatavalid);
      n_fail++;
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (avs_readdatavalid !== 1'b0 || avs_readdata !== 16'h0) begin
      $display("FAIL rst_async got v=%b d=%h want v=0 d=0",
               avs_readdatavalid, avs_readdata);
      n_fail++;
    end
    tick();
    n_tests++;
    if (avs_readdatavalid !== 1'b0) begin
      $display("FAIL rst_held_rv got %b want 0", avs_readdatavalid);
      n_fail++;
    end
    avs_chipselect = 1'b0;
    avs_read       = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    n_tests++;
    if ({irq, log_ready} !== 2'b00) begin
      $display("FAIL rst_outs got %b want 00", {irq, log_ready});
      n_fail++;
    end
    for (int i = 0; i < 4; i++) begin
      csr_rd(2'(i), d);
      n_tests++;
      if (d !== 32'h0) begin
        $display("FAIL rst_csr%0d got %h want 0", i, d);
        n_fail++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_circular();
    test_wrap();
    test_stop();
    test_byte_lanes();
    test_collision();
    test_clear_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
